// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the carry-select chunk sequencer.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    localparam int unsigned DEF_CHUNK_W = 4;
    localparam int unsigned DEF_NCHUNKS = 4;

    function automatic int unsigned idx_width(input int unsigned nchunks);
        return (nchunks <= 2) ? 1 : $clog2(nchunks);
    endfunction

endpackage

// File: rtl/csa_chunk_sequencer.sv
// Feeds a wide add through an external CHUNK_W-bit carry-select core, LSB chunk first.
// Optional signed-overflow output enabled by defining CSA_SEQ_OVF_EN.
module csa_chunk_sequencer
    import csa_seq_pkg::*;
#(
    parameter int unsigned  CHUNK_W = DEF_CHUNK_W,
    parameter int unsigned  NCHUNKS = DEF_NCHUNKS,
    localparam int unsigned TOTAL_W = CHUNK_W * NCHUNKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] in_a,
    input  logic [TOTAL_W-1:0] in_b,
    input  logic               in_cin,
    output logic [CHUNK_W-1:0] add_a,
    output logic [CHUNK_W-1:0] add_b,
    output logic               add_cin,
    input  logic [CHUNK_W-1:0] add_sum,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_sum,
    output logic               out_cout
`ifdef CSA_SEQ_OVF_EN
    ,
    output logic               out_ovf
`endif
);

    localparam int unsigned IDX_W = idx_width(NCHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNKS - 1);

    seq_state_e         state_q;
    logic [TOTAL_W-1:0] a_q;
    logic [TOTAL_W-1:0] b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TOTAL_W-1:0] sum_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
`ifdef CSA_SEQ_OVF_EN
    logic               ovf_q;
    logic               msb_cin;

    // Carry into the MSB is recovered from the MSB sum bit of the last chunk.
    assign msb_cin = add_a[CHUNK_W-1] ^ add_b[CHUNK_W-1] ^ add_sum[CHUNK_W-1];
    assign out_ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        carry_q    <= in_cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    sum_q[idx_q*CHUNK_W +: CHUNK_W] <= add_sum;
                    carry_q <= add_cout;
                    a_q     <= a_q >> CHUNK_W;
                    b_q     <= b_q >> CHUNK_W;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= add_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
`ifdef CSA_SEQ_OVF_EN
                        ovf_q       <= msb_cin ^ add_cout;
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign add_a     = (state_q == StRun) ? a_q[CHUNK_W-1:0] : '0;
    assign add_b     = (state_q == StRun) ? b_q[CHUNK_W-1:0] : '0;
    assign add_cin   = (state_q == StRun) ? carry_q : 1'b0;

endmodule

// File: tb/tb_csa_chunk_sequencer.sv
// Directed bench for csa_chunk_sequencer with a behavioural 4-bit adder core.
module tb_csa_chunk_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
`ifdef CSA_SEQ_OVF_EN
    logic        out_ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    // Stand-in for the external carry-select core.
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    csa_chunk_sequencer #(.CHUNK_W(4), .NCHUNKS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef CSA_SEQ_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        tests++;
        if (out_sum !== 16'h0000 || out_cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: sum=%h cout=%b, want 0000 0", out_sum, out_cout);
        end
        tests++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL reset_add: a=%h b=%h cin=%b, want 0 0 0", add_a, add_b, add_cin);
        end
    endtask

    task automatic test_carry_chain();
        logic [3:0] cin_seq;
        logic       early;
        early = 1'b0;
        accept(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cin_seq[k] = add_cin;
            if (out_valid !== 1'b0) early = 1'b1;
            step(1);
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL chain_latency: out_valid rose early, want 4 edges after accept");
        end
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b1) begin
            fails++;
            $display("FAIL chain_result: v=%b sum=%h cout=%b, want 1 0000 1",
                     out_valid, out_sum, out_cout);
        end
        tests++;
        if (cin_seq !== 4'b1110) begin
            fails++;
            $display("FAIL chain_cin_seq: got %b (chunk3..0), want 1110", cin_seq);
        end
        drain();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL chain_handoff: v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_slices();
        logic [15:0] a_seq;
        accept(16'h1234, 16'h4321, 1'b1);
        for (int k = 0; k < 4; k++) begin
            a_seq[k*4 +: 4] = add_a;
            step(1);
        end
        tests++;
        if (a_seq !== 16'h1234) begin
            fails++;
            $display("FAIL slice_add_a: got %h (chunk3..0), want 1234", a_seq);
        end
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 16'h5556 || out_cout !== 1'b0) begin
            fails++;
            $display("FAIL slice_result: v=%b sum=%h cout=%b, want 1 5556 0",
                     out_valid, out_sum, out_cout);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic held;
        held = 1'b1;
        accept(16'h00FF, 16'h0F01, 1'b0);
        step(4);
        for (int k = 0; k < 3; k++) begin
            if (out_valid !== 1'b1 || out_sum !== 16'h1000 || out_cout !== 1'b0 ||
                in_ready !== 1'b0) held = 1'b0;
            step(1);
        end
        tests++;
        if (!held) begin
            fails++;
            $display("FAIL bp_hold: v=%b sum=%h cout=%b rdy=%b, want 1 1000 0 0",
                     out_valid, out_sum, out_cout, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 16'h1111;
        in_b = 16'h2222;
        in_cin = 1'b0;
        in_valid = 1'b1;
        step(1);
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_same_cycle: rdy=%b v=%b, want 1 0", in_ready, out_valid);
        end
        step(1);
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || add_a !== 4'h1 || add_b !== 4'h2) begin
            fails++;
            $display("FAIL bp_next_accept: rdy=%b a=%h b=%h, want 0 1 2", in_ready, add_a, add_b);
        end
        step(4);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 16'h3333 || out_cout !== 1'b0) begin
            fails++;
            $display("FAIL bp_second_op: v=%b sum=%h cout=%b, want 1 3333 0",
                     out_valid, out_sum, out_cout);
        end
        drain();
    endtask

    task automatic test_reset_mid_run();
        logic spurious;
        spurious = 1'b0;
        accept(16'hAAAA, 16'h5555, 1'b0);
        step(1);
        #4;
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_a !== 4'h0 || add_cin !== 1'b0 ||
            out_sum !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_async: rdy=%b v=%b a=%h cin=%b sum=%h, want 1 0 0 0 0000",
                     in_ready, out_valid, add_a, add_cin, out_sum);
        end
        step(1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid !== 1'b0) spurious = 1'b1;
            step(1);
        end
        tests++;
        if (spurious) begin
            fails++;
            $display("FAIL mid_reset_no_valid: out_valid=1 after reset, want 0");
        end
        accept(16'h0F0F, 16'hF0F0, 1'b0);
        step(4);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 16'hFFFF || out_cout !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_next_op: v=%b sum=%h cout=%b, want 1 ffff 0",
                     out_valid, out_sum, out_cout);
        end
        drain();
    endtask

`ifdef CSA_SEQ_OVF_EN
    task automatic test_ovf();
        accept(16'h7FFF, 16'h0001, 1'b0);
        step(4);
        tests++;
        if (out_ovf !== 1'b1 || out_cout !== 1'b0 || out_sum !== 16'h8000) begin
            fails++;
            $display("FAIL ovf_pos: ovf=%b cout=%b sum=%h, want 1 0 8000", out_ovf, out_cout, out_sum);
        end
        drain();
        accept(16'hFFFF, 16'h0001, 1'b0);
        step(4);
        tests++;
        if (out_ovf !== 1'b0 || out_cout !== 1'b1) begin
            fails++;
            $display("FAIL ovf_wrap: ovf=%b cout=%b, want 0 1", out_ovf, out_cout);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_slices();
        test_backpressure();
        test_reset_mid_run();
`ifdef CSA_SEQ_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
